// File: rtl/descramble_rx.sv
// descramble_rx: per-lane PCIe Gen1 receive descrambler with ordered-set tracking.
// Optional DisableScramble input when DESCRAMBLE_BYPASS_EN is defined.
module descramble_rx #(
    parameter int          TS_LEN = 16,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic        ClkPci,
    input  logic        ResetPci,
    input  logic        InValid,
    input  logic [7:0]  InData,
    input  logic        InK,
`ifdef DESCRAMBLE_BYPASS_EN
    input  logic        DisableScramble,
`endif
    output logic        OutValid,
    output logic [7:0]  OutData,
    output logic        OutK,
    output logic        OutOsSym,
    output logic [15:0] LfsrState
);
    typedef enum logic [1:0] {SCR, OS_HEAD, OS_K, TS_BODY} state_t;
    localparam int CW = $clog2(TS_LEN + 1);
    localparam logic [CW-1:0] TS_END = CW'(TS_LEN);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d, lfsr_adv, hi16;
    logic [7:0]    key, data_d;
    logic          is_com, is_skp, os_d, byp;
`ifdef DESCRAMBLE_BYPASS_EN
    assign byp = DisableScramble;
`else
    assign byp = 1'b0;
`endif
    assign is_com   = InK && InData == 8'hBC;
    assign is_skp   = InK && InData == 8'h1C;
    assign key      = {<<{lfsr_q[15:8]}};
    assign hi16     = {8'h00, lfsr_q[15:8]};
    // eight serial shifts of X^16+X^5+X^4+X^3+1 collapsed into one step
    assign lfsr_adv = {lfsr_q[7:0], lfsr_q[15:8]} ^ (hi16 << 3) ^ (hi16 << 4) ^ (hi16 << 5);
    assign LfsrState = lfsr_q;
    always_comb begin
        lfsr_d  = is_com ? SEED : is_skp ? lfsr_q : lfsr_adv;
        data_d  = (InK || state_q == TS_BODY || byp) ? InData : InData ^ key;
        os_d    = is_com || state_q == OS_HEAD || state_q == TS_BODY || (state_q == OS_K && InK);
        cnt_d   = cnt_q;
        state_d = state_q;
        if (is_com) begin
            state_d = OS_HEAD;
        end else begin
            unique case (state_q)
                OS_HEAD: begin
                    cnt_d   = CW'(2);
                    state_d = (InK && InData inside {8'h1C, 8'h3C, 8'h7C}) ? OS_K :
                              (!InK || InData == 8'hF7) ? TS_BODY : SCR;
                end
                OS_K:    state_d = InK ? OS_K : SCR;
                TS_BODY: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_d == TS_END ? SCR : TS_BODY;
                end
                default: state_d = SCR;
            endcase
        end
    end
    always_ff @(posedge ClkPci) begin
        if (ResetPci) begin
            state_q  <= SCR;
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            OutValid <= 1'b0;
            OutData  <= 8'h00;
            OutK     <= 1'b0;
            OutOsSym <= 1'b0;
        end else if (InValid) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            OutValid <= 1'b1;
            OutData  <= data_d;
            OutK     <= InK;
            OutOsSym <= os_d;
        end else begin
            OutValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_descramble_rx.sv
// tb_descramble_rx: directed table, corner sequences and random stream against a symbol-level model.
module tb_descramble_rx;
    localparam int          TS_LEN = 16;
    localparam logic [15:0] SEED   = 16'hFFFF;
    logic        clk = 1'b0, rst = 1'b1, v = 1'b0, k = 1'b0, dis = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        ov, ok, oos;
    logic [7:0]  od;
    logic [15:0] lst;
    int n_pass = 0, n_total = 0;
    always #5 clk = ~clk;
    descramble_rx #(.TS_LEN(TS_LEN), .SEED(SEED)) dut (
        .ClkPci(clk), .ResetPci(rst), .InValid(v), .InData(d), .InK(k),
`ifdef DESCRAMBLE_BYPASS_EN
        .DisableScramble(dis),
`endif
        .OutValid(ov), .OutData(od), .OutK(ok), .OutOsSym(oos), .LfsrState(lst)
    );
    // reference model: serial LFSR, symbol classification by ordered-set position
    logic [15:0] m_lfsr = SEED;
    logic        m_v = 0, m_k = 0, m_os = 0;
    logic [7:0]  m_d = 0;
    int          m_mode = 0;
    int          ts_left = 0;
    function automatic logic [15:0] shift8(input logic [15:0] l);
        for (int i = 0; i < 8; i++) l = l[15] ? ((l << 1) ^ 16'h0039) : (l << 1);
        return l;
    endfunction
    function automatic logic [7:0] key_of(input logic [15:0] l);
        logic [7:0] kk;
        for (int i = 0; i < 8; i++) kk[i] = l[15 - i];
        return kk;
    endfunction
    task automatic model_step(input logic r, vv, kk, input logic [7:0] dd, input logic byp);
        if (r) begin
            m_lfsr = SEED; m_mode = 0; ts_left = 0;
            m_v = 0; m_k = 0; m_d = 0; m_os = 0;
            return;
        end
        m_v = vv;
        if (!vv) return;
        m_k = kk;
        if (kk && dd == 8'hBC) begin
            m_lfsr = SEED; m_mode = 1; m_os = 1; m_d = dd;
            return;
        end
        m_d  = (!kk && m_mode != 3 && !byp) ? dd ^ key_of(m_lfsr) : dd;
        m_os = m_mode == 1 || m_mode == 3 || (m_mode == 2 && kk);
        if (!(kk && dd == 8'h1C)) m_lfsr = shift8(m_lfsr);
        if (m_mode == 1) begin
            if (kk && (dd == 8'h1C || dd == 8'h3C || dd == 8'h7C)) m_mode = 2;
            else if (!kk || dd == 8'hF7) begin m_mode = 3; ts_left = TS_LEN - 2; end
            else m_mode = 0;
        end else if (m_mode == 2) begin
            if (!kk) m_mode = 0;
        end else if (m_mode == 3) begin
            ts_left--;
            if (ts_left == 0) m_mode = 0;
        end
    endtask
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic cyc(input logic r, vv, kk, input logic [7:0] dd, input string nm);
        rst = r; v = vv; k = kk; d = dd;
        model_step(r, vv, kk, dd, dis);
        @(posedge clk);
        @(negedge clk);
        check(nm, {ov, ok, od, lst, ov & oos}, {m_v, m_k, m_d, m_lfsr, m_v & m_os});
    endtask
    typedef struct {
        logic r, v, k; logic [7:0] d;
        logic ev, ek; logic [7:0] ed; logic eos;
    } vec_t;
    vec_t tbl[$];
    int osn;
    logic [15:0] l0;
    initial begin
        tbl.push_back('{1, 1, 0, 8'h5A, 0, 0, 8'h00, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'hFF, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'h17, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'hC0, 0});
        tbl.push_back('{0, 1, 1, 8'hBC, 1, 1, 8'hBC, 1});
        tbl.push_back('{0, 1, 1, 8'h1C, 1, 1, 8'h1C, 1});
        tbl.push_back('{0, 1, 1, 8'h1C, 1, 1, 8'h1C, 1});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'hFF, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'h17, 0});
        tbl.push_back('{0, 0, 0, 8'h33, 0, 0, 8'h17, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'hC0, 0});
        tbl.push_back('{0, 1, 1, 8'hBC, 1, 1, 8'hBC, 1});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'hFF, 1});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 8'h00, 1});
        tbl.push_back('{0, 1, 1, 8'h1C, 1, 1, 8'h1C, 1});
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].k, tbl[i].d, "model");
            check($sformatf("tbl%0d", i), {ov, ok, od, (tbl[i].ev | tbl[i].r) & oos},
                  {tbl[i].ev, tbl[i].ek, tbl[i].ed, (tbl[i].ev | tbl[i].r) & tbl[i].eos});
        end
        // full TS: COM, PAD, PAD, 13 data -> 16 ordered-set symbols, then descrambling resumes
        cyc(0, 1, 1, 8'hBC, "ts_com");
        osn = int'(oos);
        for (int i = 0; i < 2; i++) begin cyc(0, 1, 1, 8'hF7, "ts_pad"); osn += int'(oos); end
        for (int i = 0; i < 13; i++) begin
            cyc(0, 1, 0, 8'h4A, "ts_body"); osn += int'(oos);
            check("ts_raw", od, 8'h4A);
        end
        cyc(0, 1, 0, 8'h00, "ts_after");
        check("ts_len", osn, 16);
        check("ts_exit_os", oos, 0);
        // COM as 7th symbol of a TS restarts the ordered set
        cyc(0, 1, 1, 8'hBC, "trunc_com");
        cyc(0, 1, 1, 8'hF7, "trunc_pad");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h4A, "trunc_body");
        cyc(0, 1, 1, 8'hBC, "re_com");
        check("re_com_lfsr", lst, 16'hFFFF);
        osn = int'(oos);
        cyc(0, 1, 1, 8'hF7, "re_pad"); osn += int'(oos);
        for (int i = 0; i < 14; i++) begin cyc(0, 1, 0, 8'h4A, "re_body"); osn += int'(oos); end
        check("re_ts_len", osn, 16);
        cyc(0, 1, 0, 8'h00, "re_after");
        check("re_exit_os", oos, 0);
        // five idle cycles freeze the LFSR
        cyc(0, 1, 0, 8'h00, "stall_pre");
        l0 = lst;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 8'($urandom), "stall");
            check("stall_valid", ov, 0);
        end
        check("stall_lfsr", lst, l0);
        cyc(0, 1, 0, 8'h00, "stall_resume");
        // reset inside TS_BODY
        cyc(0, 1, 1, 8'hBC, "rst_com");
        cyc(0, 1, 1, 8'hF7, "rst_pad");
        cyc(0, 1, 0, 8'h4A, "rst_body");
        cyc(1, 1, 0, 8'h4A, "rst_mid");
        check("rst_outs", {ov, ok, od, oos, lst}, {1'b0, 1'b0, 8'h00, 1'b0, 16'hFFFF});
        cyc(0, 1, 0, 8'h00, "rst_after");
        check("rst_first", od, 8'hFF);
`ifdef DESCRAMBLE_BYPASS_EN
        cyc(1, 0, 0, 8'h00, "byp_rst");
        dis = 1'b1;
        cyc(0, 1, 0, 8'h00, "byp0"); check("byp0_d", od, 8'h00);
        cyc(0, 1, 0, 8'h00, "byp1"); check("byp1_d", od, 8'h00);
        dis = 1'b0;
        cyc(0, 1, 0, 8'h00, "byp2"); check("byp2_d", od, 8'hC0);
`endif
        // random stream with occasional resets, idles and ordered sets
        for (int i = 0; i < 3000; i++) begin
            logic rr, vv, kk;
            logic [7:0] dd;
            int p;
            logic [7:0] ks[6];
            ks = '{8'hF7, 8'h3C, 8'h7C, 8'hFB, 8'hFD, 8'h5C};
            rr = $urandom_range(0, 299) == 0;
            vv = $urandom_range(0, 9) != 0;
            p  = $urandom_range(0, 29);
            kk = p < 8;
            dd = p < 2 ? 8'hBC : p < 4 ? 8'h1C : p < 8 ? ks[$urandom_range(0, 5)] : 8'($urandom);
`ifdef DESCRAMBLE_BYPASS_EN
            if ($urandom_range(0, 49) == 0) dis = ~dis;
`endif
            cyc(rr, vv, kk, dd, "rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
